// File: rtl/tage_bank.sv
// Tagged TAGE predictor component: one bank of {valid, tag, useful, ctr}
// entries with registered read ports, a single update/allocate write port,
// a post-reset init sweep and periodic alternating MSB/LSB useful decay.
module tage_bank #(
  parameter int unsigned IDX_BITS   = 6,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned CNT_BITS   = 3,
  parameter int unsigned USF_BITS   = 2,
  parameter int unsigned RD_PORTS   = 2,
  parameter int unsigned DECAY_BITS = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         OUT_ready,
  input  logic [RD_PORTS*IDX_BITS-1:0] IN_rdAddr,
  input  logic [RD_PORTS*TAG_BITS-1:0] IN_rdTag,
  output logic [RD_PORTS-1:0]          OUT_rdHit,
  output logic [RD_PORTS-1:0]          OUT_rdTaken,
  output logic [RD_PORTS-1:0]          OUT_rdWeak,
  input  logic                         IN_wrValid,
  input  logic                         IN_wrOp,
  input  logic [IDX_BITS-1:0]          IN_wrAddr,
  input  logic [TAG_BITS-1:0]          IN_wrTag,
  input  logic                         IN_wrTaken,
  input  logic                         IN_wrUseful,
  input  logic                         IN_anyAlloc,
  output logic                         OUT_wrAlloc
);

  localparam int unsigned SIZE = 1 << IDX_BITS;

  // Counter reference points: the two centre states and saturation limits.
  localparam logic [CNT_BITS-1:0] CTR_WEAK_T  = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0] CTR_MAX     = '1;
  localparam logic [USF_BITS-1:0] USF_MAX     = '1;
  localparam logic [USF_BITS-1:0] USF_MSB     = {1'b1, {(USF_BITS-1){1'b0}}};
  localparam logic [USF_BITS-1:0] USF_LSB     = {{(USF_BITS-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [USF_BITS-1:0] useful;
    logic [CNT_BITS-1:0] ctr;
  } entry_t;

  localparam entry_t INIT_ENTRY = '{valid: 1'b0, tag: '0, useful: '0, ctr: CTR_WEAK_NT};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state;
  state_t                nextState;
  logic [IDX_BITS-1:0]   sweepPtr;
  logic [DECAY_BITS-1:0] decayCnt;
  logic                  decayPhase;
  logic                  decayFire;
  logic [USF_BITS-1:0]   decayMask;
  logic                  isRun;

  entry_t entries     [SIZE];
  entry_t entriesNext [SIZE];

  entry_t wrCur;
  entry_t wrNew;
  logic   wrTouch;

  logic [RD_PORTS-1:0] rdHitC;
  logic [RD_PORTS-1:0] rdTakenC;
  logic [RD_PORTS-1:0] rdWeakC;

  assign isRun     = (state == ST_RUN);
  assign decayFire = isRun && (decayCnt == '1);
  // Phase 0 strips the MSB, phase 1 the LSB, so a useful value ages out in two periods.
  assign decayMask = decayPhase ? ~USF_LSB : ~USF_MSB;

  // Next-state logic: the sweep ends once the last entry has been written.
  always_comb begin
    nextState = state;
    case (state)
      ST_INIT: if (sweepPtr == IDX_BITS'(SIZE - 1)) nextState = ST_RUN;
      ST_RUN:  nextState = ST_RUN;
      default: nextState = ST_INIT;
    endcase
  end

  // State, sweep pointer, decay timer and ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      sweepPtr   <= '0;
      decayCnt   <= '0;
      decayPhase <= 1'b0;
      OUT_ready  <= 1'b0;
    end else begin
      state     <= nextState;
      OUT_ready <= (nextState == ST_RUN);
      if (state == ST_INIT) begin
        sweepPtr <= sweepPtr + IDX_BITS'(1);
      end
      if (isRun) begin
        decayCnt <= decayCnt + DECAY_BITS'(1);
        if (decayFire) begin
          decayPhase <= ~decayPhase;
        end
      end
    end
  end

  // Write port: computes the new entry for UPDATE / ALLOC from the pre-write contents.
  always_comb begin
    wrCur       = entries[IN_wrAddr];
    wrNew       = wrCur;
    wrTouch     = 1'b0;
    OUT_wrAlloc = 1'b0;
    if (isRun && IN_wrValid) begin
      if (!IN_wrOp) begin
        wrTouch = 1'b1;
        if (IN_wrTaken) begin
          if (wrCur.ctr != CTR_MAX) wrNew.ctr = wrCur.ctr + CNT_BITS'(1);
        end else begin
          if (wrCur.ctr != '0) wrNew.ctr = wrCur.ctr - CNT_BITS'(1);
        end
        if (IN_wrUseful) begin
          if (wrCur.useful != USF_MAX) wrNew.useful = wrCur.useful + USF_BITS'(1);
        end else begin
          if (wrCur.useful != '0) wrNew.useful = wrCur.useful - USF_BITS'(1);
        end
      end else if (wrCur.useful == '0) begin
        OUT_wrAlloc  = 1'b1;
        wrTouch      = 1'b1;
        wrNew.valid  = 1'b1;
        wrNew.tag    = IN_wrTag;
        wrNew.useful = '0;
        wrNew.ctr    = IN_wrTaken ? CTR_WEAK_T : CTR_WEAK_NT;
      end else if (!IN_anyAlloc) begin
        // Refused allocation ages the occupant; useful is nonzero here.
        wrTouch      = 1'b1;
        wrNew.useful = wrCur.useful - USF_BITS'(1);
      end
    end
  end

  // Array next value: decay on all entries, then sweep or write overrides its one entry.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      entriesNext[IDX_BITS'(i)] = entries[IDX_BITS'(i)];
      if (decayFire) begin
        entriesNext[IDX_BITS'(i)].useful = entries[IDX_BITS'(i)].useful & decayMask;
      end
    end
    if (state == ST_INIT) begin
      entriesNext[sweepPtr] = INIT_ENTRY;
    end else if (wrTouch) begin
      entriesNext[IN_wrAddr] = wrNew;
    end
  end

  // Table storage; contents are established by the init sweep, not by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entries <= entriesNext;
    end
  end

  // Per-port lookup on the pre-write array contents; forced low until the sweep is done.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    entry_t rdEnt;
    assign rdEnt       = entries[IN_rdAddr[p*IDX_BITS +: IDX_BITS]];
    assign rdHitC[p]   = isRun && rdEnt.valid && (rdEnt.tag == IN_rdTag[p*TAG_BITS +: TAG_BITS]);
    assign rdTakenC[p] = isRun && rdEnt.ctr[CNT_BITS-1];
    assign rdWeakC[p]  = isRun && ((rdEnt.ctr == CTR_WEAK_NT) || (rdEnt.ctr == CTR_WEAK_T));
  end

  // Registered read results.
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_rdHit   <= '0;
      OUT_rdTaken <= '0;
      OUT_rdWeak  <= '0;
    end else begin
      OUT_rdHit   <= rdHitC;
      OUT_rdTaken <= rdTakenC;
      OUT_rdWeak  <= rdWeakC;
    end
  end

endmodule

// File: tb/tb_tage_bank.sv
// Scoreboard bench for tage_bank (DECAY_BITS=4): stimulus pushes expected
// read/alloc responses, a negedge monitor pops and compares them.
module tb_tage_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [11:0] rdAddr;
  logic [15:0] rdTag;
  logic [1:0]  rdHit;
  logic [1:0]  rdTaken;
  logic [1:0]  rdWeak;
  logic        wrValid;
  logic        wrOp;
  logic [5:0]  wrAddr;
  logic [7:0]  wrTag;
  logic        wrTaken;
  logic        wrUseful;
  logic        anyAlloc;
  logic        wrAlloc;

  logic        rdReq;
  logic        rdReqQ;
  logic        allocChk;
  logic        done;
  int          sinceRst;
  int          checks = 0;
  int          errors = 0;

  logic [6:0]  rdExpQ[$];
  string       rdNameQ[$];
  logic        allocExpQ[$];
  string       allocNameQ[$];

  logic [6:0]  expRd;
  logic [6:0]  gotRd;
  logic        expAl;
  string       nm;

  tage_bank #(.DECAY_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .OUT_ready  (ready),
    .IN_rdAddr  (rdAddr),
    .IN_rdTag   (rdTag),
    .OUT_rdHit  (rdHit),
    .OUT_rdTaken(rdTaken),
    .OUT_rdWeak (rdWeak),
    .IN_wrValid (wrValid),
    .IN_wrOp    (wrOp),
    .IN_wrAddr  (wrAddr),
    .IN_wrTag   (wrTag),
    .IN_wrTaken (wrTaken),
    .IN_wrUseful(wrUseful),
    .IN_anyAlloc(anyAlloc),
    .OUT_wrAlloc(wrAlloc)
  );

  always #5 clk = ~clk;

  // Bench-owned timebase: edges since reset release; decay edges are those with value%16==15 after 64.
  always @(posedge clk) begin
    if (rst) sinceRst <= 0;
    else     sinceRst <= sinceRst + 1;
    rdReqQ <= rdReq;
  end

  // Monitor: compares registered read results and the combinational alloc grant.
  always @(negedge clk) begin
    if (rdReqQ) begin
      checks = checks + 1;
      if (rdExpQ.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rd-queue: read result present, required an expectation");
      end else begin
        expRd = rdExpQ.pop_front();
        nm    = rdNameQ.pop_front();
        gotRd = {ready, rdHit, rdTaken, rdWeak};
        if (gotRd !== expRd) begin
          errors = errors + 1;
          $display("FAIL %s: got ready=%b hit=%b taken=%b weak=%b, required ready=%b hit=%b taken=%b weak=%b",
                   nm, gotRd[6], gotRd[5:4], gotRd[3:2], gotRd[1:0],
                   expRd[6], expRd[5:4], expRd[3:2], expRd[1:0]);
        end
      end
    end
    if (allocChk) begin
      checks = checks + 1;
      if (allocExpQ.size() == 0) begin
        errors = errors + 1;
        $display("FAIL alloc-queue: alloc probe present, required an expectation");
      end else begin
        expAl = allocExpQ.pop_front();
        nm    = allocNameQ.pop_front();
        if (wrAlloc !== expAl) begin
          errors = errors + 1;
          $display("FAIL %s: got OUT_wrAlloc=%b, required %b", nm, wrAlloc, expAl);
        end
      end
    end
    if (done) begin
      checks = checks + 1;
      if (rdExpQ.size() != 0 || allocExpQ.size() != 0) begin
        errors = errors + 1;
        $display("FAIL drain: got %0d rd / %0d alloc expectations left, required 0",
                 rdExpQ.size(), allocExpQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    rdReq    = 1'b0;
    allocChk = 1'b0;
    wrValid  = 1'b0;
  endtask

  task automatic setRead(input logic [5:0] a0, input logic [7:0] t0,
                         input logic [5:0] a1, input logic [7:0] t1,
                         input logic eReady, input logic [1:0] eHit,
                         input logic [1:0] eTaken, input logic [1:0] eWeak,
                         input string name);
    rdAddr = {a1, a0};
    rdTag  = {t1, t0};
    rdReq  = 1'b1;
    rdExpQ.push_back({eReady, eHit, eTaken, eWeak});
    rdNameQ.push_back(name);
  endtask

  task automatic setUpdate(input logic [5:0] a, input logic tk, input logic us);
    wrValid  = 1'b1;
    wrOp     = 1'b0;
    wrAddr   = a;
    wrTaken  = tk;
    wrUseful = us;
    anyAlloc = 1'b0;
  endtask

  task automatic setAlloc(input logic [5:0] a, input logic [7:0] t, input logic tk,
                          input logic any, input logic eAlloc, input string name);
    wrValid  = 1'b1;
    wrOp     = 1'b1;
    wrAddr   = a;
    wrTag    = t;
    wrTaken  = tk;
    anyAlloc = any;
    allocChk = 1'b1;
    allocExpQ.push_back(eAlloc);
    allocNameQ.push_back(name);
  endtask

  // Sweep-period reads: everything reads 0; ready only after the 64th edge.
  task automatic sweep(input int n);
    for (int i = 1; i <= n; i++) begin
      setRead(6'(i), 8'(i), 6'd5, 8'hA3, (i == 64), 2'b00, 2'b00, 2'b00,
              $sformatf("sweep%0d", i));
      step();
    end
  endtask

  // Advance to the start of a decay window whose upcoming decay has the given phase.
  task automatic waitWindow(input int phase);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (sinceRst >= 64 && (sinceRst % 16) == 0 && (((sinceRst - 64) / 16) % 2) == phase)
        found = 1'b1;
      else
        step();
    end
    if (!found) begin
      $display("FAIL window: got no decay window, required phase %0d", phase);
      $fatal(1, "window search");
    end
  endtask

  initial begin
    rst = 1'b1; rdAddr = '0; rdTag = '0; rdReq = 1'b0; allocChk = 1'b0; done = 1'b0;
    wrValid = 1'b0; wrOp = 1'b0; wrAddr = '0; wrTag = '0; wrTaken = 1'b0;
    wrUseful = 1'b0; anyAlloc = 1'b0;
    step();
    rst = 1'b0;
    sweep(64);

    // Allocation, tag match/miss and read-before-write.
    setAlloc(6'd5, 8'hA3, 1'b1, 1'b0, 1'b1, "alloc5");
    setRead(6'd6, 8'h00, 6'd5, 8'hA3, 1'b1, 2'b00, 2'b00, 2'b11, "alloc5-rbw");
    step();
    setRead(6'd5, 8'hA3, 6'd5, 8'hA4, 1'b1, 2'b01, 2'b11, 2'b11, "alloc5-hit");
    step();

    // Counter saturating increment then decrement.
    setUpdate(6'd5, 1'b1, 1'b0);
    setRead(6'd5, 8'hA3, 6'd6, 8'h00, 1'b1, 2'b01, 2'b01, 2'b11, "upd-rbw-ctr4");
    step();
    setUpdate(6'd5, 1'b1, 1'b0);
    setRead(6'd5, 8'hA3, 6'd5, 8'hA3, 1'b1, 2'b11, 2'b11, 2'b00, "ctr5");
    step();
    setUpdate(6'd5, 1'b1, 1'b0); step();
    setUpdate(6'd5, 1'b1, 1'b0); step();
    setRead(6'd5, 8'hA3, 6'd5, 8'hA4, 1'b1, 2'b01, 2'b11, 2'b00, "ctr7-sat");
    step();
    for (int j = 0; j < 8; j++) begin
      setUpdate(6'd5, 1'b0, 1'b0);
      if (j == 4) setRead(6'd5, 8'hA3, 6'd5, 8'hA3, 1'b1, 2'b11, 2'b00, 2'b11, "ctr3");
      step();
    end
    setRead(6'd5, 8'hA3, 6'd7, 8'h00, 1'b1, 2'b01, 2'b00, 2'b10, "ctr0-sat");
    step();

    // Useful handling on refused allocations.
    waitWindow(0);
    setUpdate(6'd7, 1'b1, 1'b1); step();
    setUpdate(6'd7, 1'b1, 1'b1); step();
    setAlloc(6'd7, 8'h55, 1'b0, 1'b0, 1'b0, "alloc7-u2"); step();
    setAlloc(6'd7, 8'h55, 1'b0, 1'b1, 1'b0, "alloc7-u1-any"); step();
    setAlloc(6'd7, 8'h55, 1'b0, 1'b0, 1'b0, "alloc7-u1"); step();
    setAlloc(6'd7, 8'h55, 1'b0, 1'b0, 1'b1, "alloc7-u0"); step();
    setRead(6'd7, 8'h55, 6'd7, 8'h00, 1'b1, 2'b01, 2'b00, 2'b11, "alloc7-read");
    step();

    // Decay phase 0 (MSB) then phase 1 (LSB).
    waitWindow(0);
    for (int j = 0; j < 4; j++) begin setUpdate(6'd9, 1'b0, 1'b1); step(); end
    for (int j = 0; j < 3; j++) begin setUpdate(6'd10, 1'b0, 1'b1); step(); end
    setAlloc(6'd9, 8'h99, 1'b0, 1'b1, 1'b0, "decay-pre9"); step();
    waitWindow(1);
    setAlloc(6'd9, 8'h99, 1'b0, 1'b0, 1'b0, "decay-msb-9a"); step();
    setAlloc(6'd9, 8'h99, 1'b0, 1'b1, 1'b1, "decay-msb-9b"); step();
    setAlloc(6'd10, 8'h10, 1'b0, 1'b1, 1'b0, "decay-msb-10"); step();
    waitWindow(0);
    setAlloc(6'd10, 8'h10, 1'b0, 1'b1, 1'b1, "decay-lsb-10"); step();

    // Write wins over decay on the same entry; other entries still decay.
    for (int j = 0; j < 3; j++) begin setUpdate(6'd11, 1'b0, 1'b1); step(); end
    for (int j = 0; j < 3; j++) begin setUpdate(6'd12, 1'b0, 1'b1); step(); end
    repeat (8) step();
    setUpdate(6'd11, 1'b0, 1'b1); step();
    waitWindow(1);
    setAlloc(6'd11, 8'h11, 1'b0, 1'b0, 1'b0, "prio-11a"); step();
    setAlloc(6'd11, 8'h11, 1'b0, 1'b0, 1'b0, "prio-11b"); step();
    setAlloc(6'd11, 8'h11, 1'b0, 1'b0, 1'b0, "prio-11c"); step();
    setAlloc(6'd11, 8'h11, 1'b0, 1'b0, 1'b1, "prio-11d"); step();
    setAlloc(6'd12, 8'h12, 1'b0, 1'b0, 1'b0, "decay-other-12a"); step();
    setAlloc(6'd12, 8'h12, 1'b0, 1'b0, 1'b1, "decay-other-12b"); step();

    // Reset mid-sweep restarts the sweep and clears prior allocations.
    rst = 1'b1; step();
    rst = 1'b0;
    sweep(30);
    rst = 1'b1;
    setRead(6'd5, 8'hA3, 6'd7, 8'h55, 1'b0, 2'b00, 2'b00, 2'b00, "rst-mid-sweep");
    step();
    rst = 1'b0;
    sweep(64);
    setRead(6'd5, 8'hA3, 6'd7, 8'h55, 1'b1, 2'b00, 2'b00, 2'b11, "post-reset-miss");
    step();
    setAlloc(6'd7, 8'h77, 1'b1, 1'b0, 1'b1, "post-reset-alloc");
    step();
    step();
    done = 1'b1;
  end

endmodule
